// File: rtl/toggle_sram_responder_pkg.sv
// Shared types and constants for the toggle req/ack SRAM responder.
// State encodings, default wait-state counts and width helpers.
package toggle_sram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int DEF_SETUP  = 1;
  localparam int DEF_ACCESS = 2;
  localparam int DEF_HOLD   = 1;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/toggle_sram_responder_wait_counter.sv
// Loadable down-counter timing the setup, access and hold phases.
// Saturates at zero; done is high whenever the count is zero.
module sram_wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/toggle_sram_responder.sv
// Toggle req/ack responder driving an asynchronous SRAM with wait states.
// Optional SRAM_IOREG_EN registers sram_dq_i and stretches reads by one cycle.
module toggle_sram_responder
  import toggle_sram_responder_pkg::*;
#(
  parameter int abits         = 18,
  parameter int dbits         = 16,
  parameter int SETUP_CYCLES  = DEF_SETUP,
  parameter int ACCESS_CYCLES = DEF_ACCESS,
  parameter int HOLD_CYCLES   = DEF_HOLD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  output logic             ack,
  input  logic             we,
  input  logic [abits-1:0] a,
  input  logic [dbits-1:0] d,
  output logic [dbits-1:0] q,
  output logic [abits-1:0] sram_a,
  output logic [dbits-1:0] sram_dq_o,
  input  logic [dbits-1:0] sram_dq_i,
  output logic             sram_dq_oe,
  output logic             sram_ce_n,
  output logic             sram_we_n,
  output logic             sram_oe_n
);

  localparam int CW = clog2(
    max3(SETUP_CYCLES, ACCESS_CYCLES, HOLD_CYCLES) + 1);

  logic [dbits-1:0] dq_src;

`ifdef SRAM_IOREG_EN
  localparam int ACC_RD = ACCESS_CYCLES;
  logic [dbits-1:0] dq_i_r;
  always_ff @(posedge clk) begin
    dq_i_r <= sram_dq_i;
  end
  assign dq_src = dq_i_r;
`else
  localparam int ACC_RD = ACCESS_CYCLES - 1;
  assign dq_src = sram_dq_i;
`endif

  state_t           state, state_nx;
  logic             we_lat, we_lat_nx;
  logic             ack_nx;
  logic [dbits-1:0] q_nx;
  logic [abits-1:0] a_nx;
  logic [dbits-1:0] dq_o_nx;
  logic             dq_oe_nx;
  logic             ce_n_nx;
  logic             we_n_nx;
  logic             oe_n_nx;
  logic             cnt_load;
  logic [CW-1:0]    cnt_val;
  logic             cnt_done;

  sram_wait_counter #(
    .W(CW)
  ) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      we_lat     <= 1'b0;
      ack        <= 1'b0;
      q          <= '0;
      sram_a     <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      state      <= state_nx;
      we_lat     <= we_lat_nx;
      ack        <= ack_nx;
      q          <= q_nx;
      sram_a     <= a_nx;
      sram_dq_o  <= dq_o_nx;
      sram_dq_oe <= dq_oe_nx;
      sram_ce_n  <= ce_n_nx;
      sram_we_n  <= we_n_nx;
      sram_oe_n  <= oe_n_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    we_lat_nx = we_lat;
    ack_nx    = ack;
    q_nx      = q;
    a_nx      = sram_a;
    dq_o_nx   = sram_dq_o;
    dq_oe_nx  = sram_dq_oe;
    ce_n_nx   = sram_ce_n;
    we_n_nx   = sram_we_n;
    oe_n_nx   = sram_oe_n;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    unique case (state)
      ST_IDLE: begin
        if (req != ack) begin
          a_nx      = a;
          dq_o_nx   = d;
          we_lat_nx = we;
          ce_n_nx   = 1'b0;
          dq_oe_nx  = we;
          cnt_load  = 1'b1;
          cnt_val   = CW'(SETUP_CYCLES - 1);
          state_nx  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          we_n_nx  = ~we_lat;
          oe_n_nx  = we_lat;
          cnt_load = 1'b1;
          cnt_val  = we_lat ? CW'(ACCESS_CYCLES - 1)
                            : CW'(ACC_RD);
          state_nx = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_done) begin
          if (!we_lat)
            q_nx = dq_src;
          we_n_nx  = 1'b1;
          oe_n_nx  = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = CW'(HOLD_CYCLES - 1);
          state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          ce_n_nx  = 1'b1;
          dq_oe_nx = 1'b0;
          ack_nx   = ~ack;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_toggle_sram_responder.sv
// Bench for toggle_sram_responder: default and stretched-timing instances,
// async SRAM models, and a memory/latency reference model.
module tb_toggle_sram_responder;

`ifdef SRAM_IOREG_EN
  localparam int IOX = 1;
`else
  localparam int IOX = 0;
`endif

  localparam int S_C [2] = '{1, 3};
  localparam int A_C [2] = '{2, 4};
  localparam int H_C [2] = '{1, 2};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        req_v  [2];
  logic        ack_v  [2];
  logic        we_v   [2];
  logic [17:0] a_v    [2];
  logic [15:0] d_v    [2];
  logic [15:0] q_v    [2];
  logic [17:0] sa_v   [2];
  logic [15:0] dqo_v  [2];
  logic [15:0] dqi_v  [2];
  logic        oe_v   [2];
  logic        ce_v   [2];
  logic        wen_v  [2];
  logic        oen_v  [2];

  logic [15:0] mem0 [8192];
  logic [15:0] mem1 [8192];

  logic [15:0] model [int];
  logic [15:0] q_exp [2];
  int wa0 [$];
  int wa1 [$];

  toggle_sram_responder u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .req        (req_v[0]),
    .ack        (ack_v[0]),
    .we         (we_v[0]),
    .a          (a_v[0]),
    .d          (d_v[0]),
    .q          (q_v[0]),
    .sram_a     (sa_v[0]),
    .sram_dq_o  (dqo_v[0]),
    .sram_dq_i  (dqi_v[0]),
    .sram_dq_oe (oe_v[0]),
    .sram_ce_n  (ce_v[0]),
    .sram_we_n  (wen_v[0]),
    .sram_oe_n  (oen_v[0])
  );

  toggle_sram_responder #(
    .abits         (18),
    .dbits         (16),
    .SETUP_CYCLES  (3),
    .ACCESS_CYCLES (4),
    .HOLD_CYCLES   (2)
  ) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .req        (req_v[1]),
    .ack        (ack_v[1]),
    .we         (we_v[1]),
    .a          (a_v[1]),
    .d          (d_v[1]),
    .q          (q_v[1]),
    .sram_a     (sa_v[1]),
    .sram_dq_o  (dqo_v[1]),
    .sram_dq_i  (dqi_v[1]),
    .sram_dq_oe (oe_v[1]),
    .sram_ce_n  (ce_v[1]),
    .sram_we_n  (wen_v[1]),
    .sram_oe_n  (oen_v[1])
  );

  assign dqi_v[0] = (!ce_v[0] && !oen_v[0]) ? mem0[sa_v[0][12:0]] : 16'hDEAD;
  assign dqi_v[1] = (!ce_v[1] && !oen_v[1]) ? mem1[sa_v[1][12:0]] : 16'hDEAD;

  always @(posedge clk) begin
    if (!ce_v[0] && !wen_v[0] && oe_v[0])
      mem0[sa_v[0][12:0]] <= dqo_v[0];
    if (!ce_v[1] && !wen_v[1] && oe_v[1])
      mem1[sa_v[1][12:0]] <= dqo_v[1];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("contend0", {31'b0, oe_v[0] & ~oen_v[0]}, 32'd0);
      chk("contend1", {31'b0, oe_v[1] & ~oen_v[1]}, 32'd0);
    end
  end

  function automatic int key(input int k, input logic [17:0] addr);
    return k * (1 << 20) + int'(addr);
  endfunction

  // One complete transaction, starting just after a rising edge.
  task automatic do_op(input int k, input logic w, input logic [17:0] addr,
                       input logic [15:0] data, input bit viol);
    int   exp_lat;
    int   exp_w;
    int   lat;
    int   width;
    bit   astable;
    bit   dstable;
    bit   oeok;
    logic a0;
    exp_lat = 1 + S_C[k] + A_C[k] + H_C[k] + ((IOX == 1 && !w) ? 1 : 0);
    exp_w   = A_C[k] + ((IOX == 1 && !w) ? 1 : 0);
    lat = 0;
    width = 0;
    astable = 1'b1;
    dstable = 1'b1;
    oeok = 1'b1;
    a0 = ack_v[k];
    we_v[k] = w;
    a_v[k] = addr;
    d_v[k] = data;
    req_v[k] = ~req_v[k];
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (sa_v[k] !== addr) astable = 1'b0;
      if (w && dqo_v[k] !== data) dstable = 1'b0;
      if (ack_v[k] !== a0) begin
        lat = n;
        if (oe_v[k] !== 1'b0) oeok = 1'b0;
        break;
      end
      if (oe_v[k] !== w) oeok = 1'b0;
      if (w ? !wen_v[k] : !oen_v[k]) width++;
      if (viol && (n == 1 || n == 2)) req_v[k] = ~req_v[k];
    end
    chk($sformatf("lat%0d_%s", k, w ? "wr" : "rd"), lat, exp_lat);
    chk($sformatf("strobe%0d", k), width, exp_w);
    chk($sformatf("addr_stable%0d", k), {31'b0, astable}, 32'd1);
    chk($sformatf("data_stable%0d", k), {31'b0, dstable}, 32'd1);
    chk($sformatf("dq_oe%0d", k), {31'b0, oeok}, 32'd1);
    chk($sformatf("ce_off%0d", k), {31'b0, ce_v[k]}, 32'd1);
    if (w) begin
      model[key(k, addr)] = data;
      if (k == 0) wa0.push_back(int'(addr));
      else        wa1.push_back(int'(addr));
    end else begin
      q_exp[k] = model[key(k, addr)];
    end
    chk($sformatf("q%0d", k), {16'b0, q_v[k]}, {16'b0, q_exp[k]});
    chk($sformatf("req_eq_ack%0d", k), {31'b0, req_v[k] ^ ack_v[k]}, 32'd0);
  endtask

  initial begin
    logic        rw;
    logic [17:0] ra;
    int          rk;
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 1'b0;
      we_v[k] = 1'b0;
      a_v[k] = '0;
      d_v[k] = '0;
      q_exp[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ack_v[0]}, 32'd0);
    chk("rst_q", {16'b0, q_v[0]}, 32'd0);
    chk("rst_sram_a", {14'b0, sa_v[0]}, 32'd0);
    chk("rst_dq_o", {16'b0, dqo_v[0]}, 32'd0);
    chk("rst_dq_oe", {31'b0, oe_v[0]}, 32'd0);
    chk("rst_ce_n", {31'b0, ce_v[0]}, 32'd1);
    chk("rst_we_n", {31'b0, wen_v[0]}, 32'd1);
    chk("rst_oe_n", {31'b0, oen_v[0]}, 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_op(0, 1'b1, 18'h0_1234, 16'hBEEF, 1'b0);
    do_op(0, 1'b0, 18'h0_1234, 16'h0000, 1'b0);
    chk("rd_beef", {16'b0, q_v[0]}, 32'h0000_BEEF);

    do_op(0, 1'b1, 18'h0_0010, 16'hAAAA, 1'b0);
    do_op(0, 1'b1, 18'h0_0011, 16'h5555, 1'b0);
    do_op(0, 1'b0, 18'h0_0010, 16'h0000, 1'b0);
    chk("b2b_rd10", {16'b0, q_v[0]}, 32'h0000_AAAA);
    do_op(0, 1'b0, 18'h0_0011, 16'h0000, 1'b0);
    chk("b2b_rd11", {16'b0, q_v[0]}, 32'h0000_5555);

    do_op(1, 1'b1, 18'h0_0ABC, 16'h1357, 1'b0);
    do_op(1, 1'b0, 18'h0_0ABC, 16'h0000, 1'b0);
    chk("sweep_rd", {16'b0, q_v[1]}, 32'h0000_1357);

    do_op(1, 1'b1, 18'h0_0123, 16'h2468, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("viol_idle_ce", {31'b0, ce_v[1]}, 32'd1);
      chk("viol_req_ack", {31'b0, req_v[1] ^ ack_v[1]}, 32'd0);
    end

    we_v[0] = 1'b1;
    a_v[0] = 18'h3_FF00;
    d_v[0] = 16'h1111;
    req_v[0] = ~req_v[0];
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (!wen_v[0]) break;
    end
    chk("reach_access", {31'b0, wen_v[0]}, 32'd0);
    reset = 1'b1;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_we_n", {31'b0, wen_v[0]}, 32'd1);
    chk("mid_rst_ce_n", {31'b0, ce_v[0]}, 32'd1);
    chk("mid_rst_dq_oe", {31'b0, oe_v[0]}, 32'd0);
    chk("mid_rst_ack", {31'b0, ack_v[0]}, 32'd0);
    q_exp[0] = '0;
    q_exp[1] = '0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", {31'b0, ce_v[0]}, 32'd1);
    do_op(0, 1'b0, 18'h0_1234, 16'h0000, 1'b0);
    chk("post_rst_rd", {16'b0, q_v[0]}, 32'h0000_BEEF);

    for (int i = 0; i < 40; i++) begin
      rk = int'($urandom_range(0, 1));
      rw = 1'(($urandom_range(0, 1)));
      if (rk == 0 && wa0.size() == 0) rw = 1'b1;
      if (rk == 1 && wa1.size() == 0) rw = 1'b1;
      if (rw)
        ra = 18'($urandom_range(0, 4095));
      else if (rk == 0)
        ra = 18'(wa0[$urandom_range(0, wa0.size() - 1)]);
      else
        ra = 18'(wa1[$urandom_range(0, wa1.size() - 1)]);
      do_op(rk, rw, ra, 16'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
